// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_pulse block.
// Holds the filter FSM state encoding and the default qualification length.
package debounce_pkg;

  localparam int unsigned STABLE_CNT_DEF = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

endpackage

// File: rtl/debounce_pulse_if.sv
// Button-side bus of debounce_pulse: raw level and enable in; filtered level,
// edge strobes and qualification status out.
interface debounce_pulse_if;

  logic btn_in;
  logic en;
  logic d_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_in, en,
    input  d_out, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  btn_in, en,
    output d_out, rise_pulse, fall_pulse, busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: clocked state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: a new synchronized level must persist for STABLE_CNT cycles
// before d_out follows it, with a one-cycle registered strobe per accepted edge.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
  parameter int unsigned CNT_W      = $clog2(STABLE_CNT + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  debounce_pulse_if.slave bus
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CNT - 1);
  localparam bit               C_ONE  = (STABLE_CNT == 1);

  logic             w_sync_q;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_d_out, w_d_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  sync_2ff u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (bus.btn_in),
    .o_sync  (w_sync_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_d_out <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_out <= w_d_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_nxt     = r_d_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;

    if (!bus.en) begin
      // Disabled: park in the stable state matching the held output level.
      w_state_nxt = r_d_out ? STABLE_HI : STABLE_LO;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        STABLE_LO: begin
          w_cnt_nxt = '0;
          if (w_sync_q) begin
            if (C_ONE) begin
              w_state_nxt = STABLE_HI;
              w_d_nxt     = 1'b1;
              w_rise_nxt  = 1'b1;
            end else begin
              w_state_nxt = WAIT_HI;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        WAIT_HI: begin
          if (!w_sync_q) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_LAST) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
            w_d_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          w_cnt_nxt = '0;
          if (!w_sync_q) begin
            if (C_ONE) begin
              w_state_nxt = STABLE_LO;
              w_d_nxt     = 1'b0;
              w_fall_nxt  = 1'b1;
            end else begin
              w_state_nxt = WAIT_LO;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        WAIT_LO: begin
          if (w_sync_q) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_LAST) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
            w_d_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.d_out      = r_d_out;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.busy       = (r_state == WAIT_HI) || (r_state == WAIT_LO);

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: two instances (STABLE_CNT=4 and 1) share
// stimulus; a run-length reference model predicts outputs after every edge.
module tb_debounce_pulse;

  localparam int N_A = 4;
  localparam int N_B = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  debounce_pulse_if if_a ();
  debounce_pulse_if if_b ();

  debounce_pulse #(.STABLE_CNT(N_A)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  debounce_pulse #(.STABLE_CNT(N_B)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));

  // Expected outputs packed as {d_out, rise_pulse, fall_pulse, busy}.
  typedef logic [3:0] exp_t;
  typedef struct {
    logic s1;
    logic s2;
    logic level;
    int   run;
  } mdl_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  mdl_t ma = '{1'b0, 1'b0, 1'b0, 0};
  mdl_t mb = '{1'b0, 1'b0, 1'b0, 0};
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (d,rise,fall,busy) at %0t", name, act, exp, $time);
  endtask

  // The output level flips once the synchronized input has disagreed with it
  // on n consecutive enabled edges; any agreeing or disabled edge restarts the run.
  function automatic exp_t model_step(inout mdl_t m, input logic b, input logic e,
                                      input logic r, input int n);
    logic rise = 1'b0;
    logic fall = 1'b0;
    if (!r) begin
      m = '{1'b0, 1'b0, 1'b0, 0};
      return 4'b0000;
    end
    if (e && (m.s2 != m.level)) m.run = m.run + 1;
    else                        m.run = 0;
    if (m.run == n) begin
      m.level = ~m.level;
      m.run   = 0;
      rise    = m.level;
      fall    = ~m.level;
    end
    m.s2 = m.s1;
    m.s1 = b;
    return {m.level, rise, fall, (m.run != 0)};
  endfunction

  function automatic exp_t obs_a();
    return {if_a.d_out, if_a.rise_pulse, if_a.fall_pulse, if_a.busy};
  endfunction

  function automatic exp_t obs_b();
    return {if_b.d_out, if_b.rise_pulse, if_b.fall_pulse, if_b.busy};
  endfunction

  // One clock of stimulus: drive on the falling edge, predict at the rising edge.
  task automatic tick(input logic b, input logic e, input logic r);
    logic prev_rstn;
    @(negedge clk);
    prev_rstn   = rstn;
    if_a.btn_in = b;
    if_b.btn_in = b;
    if_a.en     = e;
    if_b.en     = e;
    rstn        = r;
    if (prev_rstn && !r) begin
      #1;
      check("async_reset_a", obs_a(), 4'b0000);
      check("async_reset_b", obs_b(), 4'b0000);
    end
    @(posedge clk);
    qa.push_back(model_step(ma, b, e, r, N_A));
    qb.push_back(model_step(mb, b, e, r, N_B));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("sb_cnt4", obs_a(), ea);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("sb_cnt1", obs_b(), eb);
      end
    end
  end

  initial begin : driver
    logic b, e, r;
    int   hold;
    int   cyc;
    if_a.btn_in = 1'b0;
    if_b.btn_in = 1'b0;
    if_a.en     = 1'b1;
    if_b.en     = 1'b1;

    repeat (3) tick(1'b0, 1'b1, 1'b0);

    // Reset exit with the button already pressed: rise lands on edge 6.
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (i == 5) begin
        #2;
        check("edge5_busy_no_rise", obs_a(), 4'b0001);
      end
      if (i == 6) begin
        #2;
        check("edge6_rise", obs_a(), 4'b1100);
      end
    end

    repeat (8) tick(1'b0, 1'b1, 1'b1);                 // release -> fall
    repeat (2) tick(1'b1, 1'b1, 1'b1);                 // short glitch
    repeat (6) tick(1'b0, 1'b1, 1'b1);

    tick(1'b1, 1'b1, 1'b1);                            // press with enable gap
    repeat (9) tick(1'b1, 1'b0, 1'b1);
    repeat (8) tick(1'b1, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b1, 1'b1);

    repeat (4) tick(1'b1, 1'b1, 1'b1);                 // reset mid-qualification
    tick(1'b1, 1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) tick(((i / 3) % 2) == 0, 1'b1, 1'b1);

    cyc = 0;
    while (cyc < 1500) begin
      b    = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      for (int k = 0; k < hold; k++) begin
        e = ($urandom_range(0, 15) != 0);
        r = ($urandom_range(0, 149) != 0);
        tick(b, e, r);
        cyc++;
      end
    end

    repeat (6) tick(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check("sb_drained", {3'b000, (qa.size() == 0) && (qb.size() == 0)}, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 Parameter: STABLE_CNT, default 4, consecutive synchronized cycles required before a level change is accepted; legal range 1..65535.
REQ-002 Parameter: CNT_W, default $clog2(STABLE_CNT+1), width of the stability counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: btn_in  input  1  raw asynchronous switch/button level.
REQ-006 Port: en  input  1  synchronous enable for filtering.
REQ-007 Port: d_out  output  1  debounced level; drives the d input of the downstream dff stage.
REQ-008 Port: rise_pulse  output  1  one-cycle strobe when d_out goes 0->1.
REQ-009 Port: fall_pulse  output  1  one-cycle strobe when d_out goes 1->0.
REQ-010 Port: busy  output  1  high while a candidate level change is being qualified.

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer; only its second-stage output (sync_q) feeds the filter logic.
REQ-012 FSM states SHALL be STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-013 STABLE_LO: sync_q=1 -> WAIT_HI, counter=1; else stay, counter=0.
REQ-014 WAIT_HI: sync_q=1 and counter==STABLE_CNT-1 -> STABLE_HI, d_out<=1, rise_pulse<=1; sync_q=1 otherwise -> counter+1; sync_q=0 -> STABLE_LO, counter=0, no pulse.
REQ-015 STABLE_HI and WAIT_LO SHALL mirror REQ-013/014 with levels inverted; acceptance sets d_out<=0 and fall_pulse<=1.
REQ-016 With STABLE_CNT=1, state SHALL go straight from STABLE_* to the opposite STABLE_* on the first differing sync_q cycle, with no WAIT_* cycle.
REQ-017 Latency: with btn_in first sampled changed at edge 1 and held, d_out and the pulse SHALL update at edge STABLE_CNT+2.
REQ-018 rise_pulse/fall_pulse SHALL be registered, high exactly one cycle, never both high, and never high while d_out is unchanged.
REQ-019 busy SHALL equal 1 exactly in WAIT_HI/WAIT_LO.
REQ-020 A glitch lasting fewer than STABLE_CNT sync cycles SHALL leave d_out unchanged and produce no pulse.
REQ-021 The counter SHALL never exceed STABLE_CNT-1 and never wrap.
REQ-022 en=0 SHALL force the state to STABLE_<d_out level> and clear the counter; d_out holds; pulses 0. The synchronizer keeps running.
REQ-023 en rising SHALL resume qualification from a zero count on the next cycle.

Reset
REQ-024 rstn low SHALL immediately clear the synchronizer flops, counter, d_out, rise_pulse, fall_pulse and busy, and force STABLE_LO.
REQ-025 Reset asserted mid-qualification SHALL discard the partial count; no pulse is emitted on reset entry or exit.
REQ-026 After rstn deasserts with btn_in=1, a rise_pulse SHALL occur only after full qualification per REQ-017.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM state enum typedef and the STABLE_CNT default constant.
REQ-028 The synchronizer SHALL be sub-module sync_2ff (clk, rstn, async in, sync out), instantiated once.

Verification (STABLE_CNT=4)
REQ-029 Reset then btn_in=1 held -> d_out=1 and rise_pulse=1 for one cycle at edge 6; busy high for edges 3..5.
REQ-030 btn_in=1 for 2 cycles then 0 -> d_out stays 0, no pulses, busy returns to 0.
REQ-031 From d_out=1, btn_in=0 held -> fall_pulse one cycle at edge 6; d_out=0.
REQ-032 btn_in=1 held, en=0 during edges 2..10, en=1 after -> no change while en=0; d_out rises 4 cycles after en returns.
REQ-033 rstn pulsed low during WAIT_HI (count=2) -> all outputs 0 asynchronously; no pulse; requalification restarts from 0.
REQ-034 STABLE_CNT=1, btn_in toggled every 3 cycles -> d_out follows with 3-edge latency; each transition gives exactly one matching pulse.
